// File: rtl/led_onehot_sequencer.sv
// led_onehot_sequencer: registered LED position with one-hot decode.
// The position follows the switches directly, or walks up, down or
// ping-pong, paced by an enable-gated prescaler tick.
module led_onehot_sequencer #(
    parameter int SEL_W    = 3,
    parameter int TICK_DIV = 50000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SEL_W-1:0]        sw,
    input  logic [1:0]              mode,
    input  logic                    en,
    input  logic                    load,
    output logic [(2**SEL_W)-1:0]   led,
    output logic [SEL_W-1:0]        pos,
    output logic                    tick
);

    localparam int N_LED = 2 ** SEL_W;

    // A divide-by-one prescaler still needs a one-bit counter that stays at 0.
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    localparam logic [1:0] MODE_DIRECT     = 2'b00;
    localparam logic [1:0] MODE_CHASE_UP   = 2'b01;
    localparam logic [1:0] MODE_CHASE_DOWN = 2'b10;
    localparam logic [1:0] MODE_BOUNCE     = 2'b11;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam logic [SEL_W-1:0] POS_TOP  = SEL_W'(N_LED - 1);
    localparam logic [SEL_W-1:0] POS_ZERO = '0;
    localparam logic [SEL_W-1:0] POS_ONE  = SEL_W'(1);

    logic [CNT_W-1:0] cnt;
    logic             dir;
    logic             cnt_at_last;
    logic [SEL_W-1:0] step_pos;
    logic             step_dir;

    assign cnt_at_last = (cnt == CNT_LAST);

    // Position and direction the current mode would move to on a tick.
    always_comb begin
        step_pos = pos;
        step_dir = dir;
        case (mode)
            MODE_CHASE_UP:   step_pos = pos + POS_ONE;
            MODE_CHASE_DOWN: step_pos = pos - POS_ONE;
            MODE_BOUNCE: begin
                if (dir == DIR_UP) begin
                    // Turn around at the top without lingering there.
                    if (pos == POS_TOP) begin
                        step_pos = POS_TOP - POS_ONE;
                        step_dir = DIR_DOWN;
                    end else begin
                        step_pos = pos + POS_ONE;
                    end
                end else begin
                    if (pos == POS_ZERO) begin
                        step_pos = POS_ONE;
                        step_dir = DIR_UP;
                    end else begin
                        step_pos = pos - POS_ONE;
                    end
                end
            end
            default: step_pos = pos;
        endcase
    end

    // Prescaler, tick strobe, position and bounce direction; reset > load > hold > mode action.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos  <= '0;
            cnt  <= '0;
            tick <= 1'b0;
            dir  <= DIR_UP;
        end else if (load) begin
            pos  <= sw;
            cnt  <= '0;
            tick <= 1'b0;
            // Loading an endpoint in bounce mode points the walk back inward.
            if (mode == MODE_BOUNCE) begin
                if (sw == POS_TOP) begin
                    dir <= DIR_DOWN;
                end else if (sw == POS_ZERO) begin
                    dir <= DIR_UP;
                end
            end
        end else if (!en) begin
            tick <= 1'b0;
        end else begin
            tick <= cnt_at_last;
            cnt  <= cnt_at_last ? '0 : cnt + CNT_W'(1);
            if (mode == MODE_DIRECT) begin
                pos <= sw;
            end else if (cnt_at_last) begin
                pos <= step_pos;
                dir <= step_dir;
            end
        end
    end

    // One-hot decode of the registered position.
    always_comb begin
        led      = '0;
        led[pos] = 1'b1;
    end

endmodule

// File: tb/tb_led_onehot_sequencer.sv
// Directed testbench for led_onehot_sequencer: one instance with a
// divide-by-4 prescaler and one with a tick every enabled cycle, both
// driven from the same inputs.
module tb_led_onehot_sequencer;

    logic       clk;
    logic       reset;
    logic [2:0] sw;
    logic [1:0] mode;
    logic       en;
    logic       load;

    logic [7:0] led_a;
    logic [2:0] pos_a;
    logic       tick_a;
    logic [7:0] led_b;
    logic [2:0] pos_b;
    logic       tick_b;

    int checks = 0;
    int errors = 0;

    led_onehot_sequencer #(.SEL_W(3), .TICK_DIV(4)) dut_a (
        .clk   (clk),
        .reset (reset),
        .sw    (sw),
        .mode  (mode),
        .en    (en),
        .load  (load),
        .led   (led_a),
        .pos   (pos_a),
        .tick  (tick_a)
    );

    led_onehot_sequencer #(.SEL_W(3), .TICK_DIV(1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .sw    (sw),
        .mode  (mode),
        .en    (en),
        .load  (load),
        .led   (led_b),
        .pos   (pos_b),
        .tick  (tick_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin : stim
        logic [2:0] up_seq [3];
        logic [2:0] dn_seq [2];
        logic [2:0] bnc_seq [11];
        logic [2:0] p;

        up_seq  = '{3'd7, 3'd0, 3'd1};
        dn_seq  = '{3'd0, 3'd7};
        bnc_seq = '{3'd6, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2};

        // Reset held two cycles while chasing up and enabled
        reset = 1'b1; mode = 2'b01; en = 1'b1; load = 1'b0; sw = 3'd0;
        step(); step();
        check("reset_pos", 32'(pos_a), 32'd0);
        check("reset_led", 32'(led_a), 32'h01);
        check("reset_tick", 32'(tick_a), 32'd0);
        check("reset_pos_b", 32'(pos_b), 32'd0);

        // First tick exactly TICK_DIV cycles after release
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            check("post_reset_notick", 32'(tick_a), 32'd0);
            check("post_reset_hold", 32'(pos_a), 32'd0);
        end
        step();
        check("first_tick", 32'(tick_a), 32'd1);
        check("first_tick_pos", 32'(pos_a), 32'd1);

        // Direct mode: one-cycle latency from sw to led
        mode = 2'b00; sw = 3'b101;
        step();
        check("direct_101", 32'(led_a), 32'h20);
        for (int i = 0; i < 8; i++) begin
            sw = 3'(i);
            step();
            check("direct_sweep_led", 32'(led_a), 32'(1) << i);
            check("direct_sweep_pos", 32'(pos_a), 32'(i));
        end

        // Chase up through the wrap from 6
        load = 1'b1; sw = 3'd6;
        step();
        check("load6_pos", 32'(pos_a), 32'd6);
        check("load6_tick", 32'(tick_a), 32'd0);
        load = 1'b0; mode = 2'b01;
        p = 3'd6;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 3; i++) begin
                step();
                check("up_wait_tick", 32'(tick_a), 32'd0);
                check("up_wait_pos", 32'(pos_a), 32'(p));
            end
            step();
            p = up_seq[k];
            check("up_tick", 32'(tick_a), 32'd1);
            check("up_pos", 32'(pos_a), 32'(p));
            check("up_led", 32'(led_a), 32'(1) << p);
        end

        // Chase down through the wrap from 1
        mode = 2'b10;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3; i++) begin
                step();
                check("dn_wait_tick", 32'(tick_a), 32'd0);
            end
            step();
            p = dn_seq[k];
            check("dn_tick", 32'(tick_a), 32'd1);
            check("dn_pos", 32'(pos_a), 32'(p));
            check("dn_led", 32'(led_a), 32'(1) << p);
        end

        // Freeze for 10 cycles in chase up: nothing moves, count held
        mode = 2'b01; en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("freeze_pos", 32'(pos_a), 32'd7);
            check("freeze_led", 32'(led_a), 32'h80);
            check("freeze_tick", 32'(tick_a), 32'd0);
        end
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("unfreeze_wait", 32'(tick_a), 32'd0);
        end
        step();
        check("unfreeze_tick", 32'(tick_a), 32'd1);
        check("unfreeze_pos", 32'(pos_a), 32'd0);

        // Load lands on what would have been a tick cycle
        step(); step(); step();
        load = 1'b1; sw = 3'd2;
        step();
        check("load_prio_pos", 32'(pos_a), 32'd2);
        check("load_prio_tick", 32'(tick_a), 32'd0);
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("load_prio_wait_tick", 32'(tick_a), 32'd0);
            check("load_prio_wait_pos", 32'(pos_a), 32'd2);
        end
        step();
        check("load_prio_next_tick", 32'(tick_a), 32'd1);
        check("load_prio_next_pos", 32'(pos_a), 32'd3);

        // Bounce with a tick every cycle, starting from 5 going up
        mode = 2'b11; load = 1'b1; sw = 3'd5;
        step();
        check("bounce_load5", 32'(pos_b), 32'd5);
        load = 1'b0;
        for (int k = 0; k < 11; k++) begin
            step();
            check("bounce_pos", 32'(pos_b), 32'(bnc_seq[k]));
            check("bounce_led", 32'(led_b), 32'(1) << bnc_seq[k]);
        end

        // Loading the top endpoint forces the walk downward
        load = 1'b1; sw = 3'd7;
        step();
        check("bounce_load7", 32'(pos_b), 32'd7);
        load = 1'b0;
        step();
        check("bounce_down1", 32'(pos_b), 32'd6);
        step();
        check("bounce_down2", 32'(pos_b), 32'd5);
        step();
        check("bounce_down3", 32'(pos_b), 32'd4);

        // Reset mid-walk while heading down at 4
        reset = 1'b1;
        step();
        check("midreset_pos", 32'(pos_b), 32'd0);
        check("midreset_led", 32'(led_b), 32'h01);
        check("midreset_tick", 32'(tick_b), 32'd0);
        reset = 1'b0;
        step();
        check("midreset_walk1", 32'(pos_b), 32'd1);
        step();
        check("midreset_walk2", 32'(pos_b), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
